// File: rtl/stream_fifo_burst_arbiter_if.sv
// Producer-side and FIFO-side stream signals of the burst arbiter.
// The slave modport is the arbiter view; master is the surrounding logic.
interface stream_fifo_burst_arbiter_if #(
   parameter int N_IN  = 4,
   parameter int WIDTH = 72
);
   logic [N_IN*WIDTH-1:0] i_d;
   logic [N_IN-1:0]       i_v;
   logic [N_IN-1:0]       i_r;
   logic [WIDTH-1:0]      o_d;
   logic                  o_v;
   logic                  o_r;

   modport slave  (input  i_d, i_v, o_r, output i_r, o_d, o_v);
   modport master (output i_d, i_v, o_r, input  i_r, o_d, o_v);
endinterface

// File: rtl/stream_fifo_burst_arbiter.sv
// Round-robin arbiter granting whole BURST_LEN-beat bursts into a Q_srl FIFO,
// starting a burst only when the reported occupancy leaves room for all of it.
module stream_fifo_burst_arbiter #(
   parameter int N_IN      = 4,
   parameter int WIDTH     = 72,
   parameter int DEPTH     = 6272,
   parameter int BURST_LEN = 16,
   parameter int CNT_W     = 13,
   localparam int SRC_W    = (N_IN > 1) ? $clog2(N_IN) : 1,
   localparam int BEAT_W   = $clog2(BURST_LEN + 1)
) (
   input  logic                          clock,
   input  logic                          reset,
   stream_fifo_burst_arbiter_if.slave    bus,
   input  logic [CNT_W-1:0]              fifo_count,
   output logic [SRC_W-1:0]              o_src,
   output logic                          busy,
   output logic                          burst_done
);
   typedef enum logic {IDLE, BURST} state_t;

   localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W+1)'(DEPTH);
   localparam logic [CNT_W:0]    BURST_C  = (CNT_W+1)'(BURST_LEN);
   localparam logic [BEAT_W-1:0] LAST_C   = BEAT_W'(BURST_LEN - 1);
   localparam logic [SRC_W-1:0]  LAST_SRC = SRC_W'(N_IN - 1);
   localparam logic [SRC_W:0]    N_C      = (SRC_W+1)'(N_IN);

   state_t              state_reg, state_next;
   logic [SRC_W-1:0]    ptr_reg, ptr_next;
   logic [SRC_W-1:0]    grant_reg, grant_next;
   logic [BEAT_W-1:0]   beat_reg, beat_next;
   logic                burst_done_reg, burst_done_next;

   logic [WIDTH-1:0]    data_arr [N_IN];
   logic [CNT_W:0]      free;
   logic                cand_found;
   logic [SRC_W-1:0]    cand;
   logic                hs;

   generate
      for (genvar gi = 0; gi < N_IN; gi++) begin : g_unpack
         assign data_arr[gi] = bus.i_d[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Over-reported occupancy clamps to zero room rather than wrapping.
   always_comb begin
      if ({1'b0, fifo_count} > DEPTH_C)
         free = '0;
      else
         free = DEPTH_C - {1'b0, fifo_count};
   end

   always_comb begin
      logic [SRC_W:0] sum;
      cand_found = 1'b0;
      cand       = '0;
      sum        = '0;
      for (int k = 0; k < N_IN; k++) begin
         sum = {1'b0, ptr_reg} + (SRC_W+1)'(k);
         if (sum >= N_C)
            sum = sum - N_C;
         if (!cand_found && bus.i_v[sum[SRC_W-1:0]]) begin
            cand_found = 1'b1;
            cand       = sum[SRC_W-1:0];
         end
      end
   end

   // Pure combinational passthrough of the grantee while bursting.
   assign bus.o_d = data_arr[grant_reg];
   assign bus.o_v = (state_reg == BURST) && bus.i_v[grant_reg];
   assign hs      = bus.o_v && bus.o_r;

   always_comb begin
      bus.i_r = '0;
      if (state_reg == BURST)
         bus.i_r[grant_reg] = bus.o_r;
   end

   always_comb begin
      state_next      = state_reg;
      ptr_next        = ptr_reg;
      grant_next      = grant_reg;
      beat_next       = beat_reg;
      burst_done_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cand_found && (free >= BURST_C)) begin
               grant_next = cand;
               ptr_next   = (cand == LAST_SRC) ? '0 : cand + SRC_W'(1);
               beat_next  = '0;
               state_next = BURST;
            end
         end
         BURST: begin
            if (hs) begin
               if (beat_reg == LAST_C) begin
                  state_next      = IDLE;
                  burst_done_next = 1'b1;
               end else begin
                  beat_next = beat_reg + BEAT_W'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= IDLE;
         ptr_reg        <= '0;
         grant_reg      <= '0;
         beat_reg       <= '0;
         burst_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         ptr_reg        <= ptr_next;
         grant_reg      <= grant_next;
         beat_reg       <= beat_next;
         burst_done_reg <= burst_done_next;
      end
   end

   assign o_src      = grant_reg;
   assign busy       = (state_reg == BURST);
   assign burst_done = burst_done_reg;
endmodule

// File: tb/tb_stream_fifo_burst_arbiter.sv
// Directed bench for the burst arbiter: a 4-input/16-beat instance and a
// 2-input/1-beat instance, checked against hand-derived grant timelines.
module tb_stream_fifo_burst_arbiter;
   localparam int N     = 4;
   localparam int W     = 72;
   localparam int DEPTH = 6272;
   localparam int BL    = 16;
   localparam int CW    = 13;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   stream_fifo_burst_arbiter_if #(.N_IN(N), .WIDTH(W)) bus  ();
   stream_fifo_burst_arbiter_if #(.N_IN(2), .WIDTH(W)) bus1 ();

   logic [CW-1:0] fifo_count;
   logic [CW-1:0] fifo_count1;
   logic [1:0]    o_src;
   logic [0:0]    o_src1;
   logic          busy, burst_done, busy1, burst_done1;

   stream_fifo_burst_arbiter #(.N_IN(N), .WIDTH(W), .DEPTH(DEPTH), .BURST_LEN(BL), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .bus(bus.slave), .fifo_count(fifo_count),
      .o_src(o_src), .busy(busy), .burst_done(burst_done));

   stream_fifo_burst_arbiter #(.N_IN(2), .WIDTH(W), .DEPTH(DEPTH), .BURST_LEN(1), .CNT_W(CW)) dut1 (
      .clock(clock), .reset(reset), .bus(bus1.slave), .fifo_count(fifo_count1),
      .o_src(o_src1), .busy(busy1), .burst_done(burst_done1));

   int total = 0;
   int bad   = 0;

   logic [N-1:0] req;
   logic [1:0]   req1;
   int           vhold, rhold, hold_src;
   int           seq [N];

   logic [N-1:0] s_iv, s_ir;
   logic         s_hs, s_ov, s_busy, s_done;
   logic [W-1:0] s_od;
   logic [1:0]   s_src;
   logic         s1_hs, s1_done;
   logic [0:0]   s1_src;
   logic [W-1:0] s1_od;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] mk(input int k, input int s);
      return {8'(k), 64'(s)};
   endfunction

   task automatic drive();
      bus.i_v = req;
      if (vhold > 0) begin
         bus.i_v[hold_src] = 1'b0;
         vhold--;
      end
      bus.o_r = (rhold == 0);
      if (rhold > 0)
         rhold--;
      for (int k = 0; k < N; k++)
         bus.i_d[k*W +: W] = mk(k, seq[k]);
      bus1.i_v = req1;
      bus1.o_r = 1'b1;
      bus1.i_d = {mk(1, 'hB1), mk(0, 'hB0)};
   endtask

   task automatic sample();
      @(negedge clock);
      s_iv    = bus.i_v;
      s_ir    = bus.i_r;
      s_ov    = bus.o_v;
      s_hs    = bus.o_v & bus.o_r;
      s_od    = bus.o_d;
      s_src   = o_src;
      s_busy  = busy;
      s_done  = burst_done;
      s1_hs   = bus1.o_v & bus1.o_r;
      s1_od   = bus1.o_d;
      s1_src  = o_src1;
      s1_done = burst_done1;
   endtask

   task automatic advance();
      @(posedge clock);
      #1;
      for (int k = 0; k < N; k++)
         if (s_iv[k] && s_ir[k])
            seq[k]++;
      drive();
   endtask

   task automatic cyc();
      sample();
      advance();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      req1  = '0;
      vhold = 0;
      rhold = 0;
      drive();
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   // Runs one grant for src until stop_at handshakes; checks latency to the
   // first beat, contiguity, data, and (for a full burst) the trailing IDLE.
   task automatic collect_burst(input int src, input int exp_lat, input bit stall,
                                input int stop_at, input bit last);
      int n = 0, c = 0, first = -1, lastc = -1;
      bit other = 1'b0, bad_d = 1'b0;
      logic [N-1:0] mask;
      mask = 4'(1) << src;
      while (n < stop_at && c < 100) begin
         sample();
         if (s_busy && ((s_ir & ~mask) != '0))
            other = 1'b1;
         if (s_hs) begin
            if (first < 0)
               first = c;
            lastc = c;
            if (s_od !== mk(src, seq[src]) || s_src != 2'(src))
               bad_d = 1'b1;
            n++;
            if (stall && n == 7) begin
               vhold    = 5;
               hold_src = src;
            end
            if (stall && n == 11)
               rhold = 3;
            if (n == stop_at && last)
               req = '0;
         end
         c++;
         advance();
      end
      chk("burst_beats", 72'(n), 72'(stop_at));
      chk("first_lat", 72'(first), 72'(exp_lat));
      chk("burst_span", 72'(lastc - first + 1), 72'(stop_at + (stall ? 8 : 0)));
      chk("other_ir", 72'(other), 72'(0));
      chk("beat_data", 72'(bad_d), 72'(0));
      $display("burst src=%0d beats=%0d lat=%0d span=%0d", src, n, first, lastc - first + 1);
      if (stop_at == BL) begin
         sample();
         chk("done_pulse", 72'(s_done), 72'(1));
         chk("idle_busy", 72'(s_busy), 72'(0));
         chk("idle_ov", 72'(s_ov), 72'(0));
         advance();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      logic acc;
      for (int k = 0; k < N; k++)
         seq[k] = 0;
      fifo_count  = '0;
      fifo_count1 = '0;
      hold_src    = 0;
      do_reset();

      sample();
      chk("rst_busy", 72'(s_busy), 72'(0));
      chk("rst_ov", 72'(s_ov), 72'(0));
      chk("rst_ir", 72'(s_ir), 72'(0));
      chk("rst_src", 72'(s_src), 72'(0));
      chk("rst_done", 72'(s_done), 72'(0));
      advance();

      // Single producer 0
      req = 4'b0001;
      drive();
      collect_burst(0, 1, 1'b0, BL, 1'b1);
      sample();
      chk("done_once", 72'(s_done), 72'(0));
      advance();

      // All producers valid: eight contiguous bursts in rotation
      do_reset();
      req = 4'b1111;
      drive();
      for (int b = 0; b < 8; b++)
         collect_burst(b % 4, (b == 0) ? 1 : 0, 1'b0, BL, b == 7);

      // Free-space gating
      do_reset();
      req = 4'b0100;
      acc = 1'b0;
      fifo_count = 13'(DEPTH);
      drive();
      for (int i = 0; i < 3; i++) begin
         cyc();
         acc = acc | s_busy | s_ov | (s_ir != '0);
      end
      chk("full_nogrant", 72'(acc), 72'(0));
      fifo_count = 13'd7000;
      for (int i = 0; i < 3; i++) begin
         cyc();
         acc = acc | s_busy | s_ov | (s_ir != '0);
      end
      chk("over_nogrant", 72'(acc), 72'(0));
      fifo_count = 13'd6257;
      for (int i = 0; i < 3; i++) begin
         cyc();
         acc = acc | s_busy | s_ov | (s_ir != '0);
      end
      chk("free15_nogrant", 72'(acc), 72'(0));
      fifo_count = 13'd6256;
      collect_burst(2, 1, 1'b0, BL, 1'b1);
      fifo_count = '0;

      // Mid-burst stalls on i_v and o_r with all producers requesting
      do_reset();
      req = 4'b1111;
      drive();
      collect_burst(0, 1, 1'b1, BL, 1'b1);

      // Reset at beat 9, then pointer must be back at 0
      do_reset();
      req = 4'b0100;
      drive();
      collect_burst(2, 1, 1'b0, 9, 1'b0);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      req = '0;
      drive();
      sample();
      chk("rstmid_busy", 72'(s_busy), 72'(0));
      chk("rstmid_ir", 72'(s_ir), 72'(0));
      chk("rstmid_src", 72'(s_src), 72'(0));
      advance();
      req = 4'b1001;
      drive();
      collect_burst(0, 1, 1'b0, BL, 1'b1);
      req = 4'b1000;
      drive();
      collect_burst(3, 1, 1'b0, BL, 1'b1);

      // BURST_LEN=1 instance: beats alternate 0,1 on every other cycle
      do_reset();
      req1 = 2'b11;
      drive();
      for (int c = 0; c < 8; c++) begin
         cyc();
         chk($sformatf("bl1_hs%0d", c), 72'(s1_hs), 72'(c % 2));
         chk($sformatf("bl1_done%0d", c), 72'(s1_done), 72'((c >= 2 && c % 2 == 0) ? 1 : 0));
         if (c % 2 == 1) begin
            chk($sformatf("bl1_src%0d", c), 72'(s1_src), 72'((c / 2) % 2));
            chk($sformatf("bl1_data%0d", c), s1_od, mk((c / 2) % 2, 'hB0 + (c / 2) % 2));
            $display("bl1 beat cycle=%0d src=%0d", c, s1_src);
         end
      end
      req1 = '0;
      drive();
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
